// File: rtl/inst_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the RV32IC instruction aligner.
interface inst_aligner_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_is_compressed;

    modport master (
        output fetch_valid, fetch_data, fetch_pc, flush, flush_pc, inst_ready,
        input  fetch_ready, inst_valid, inst_data, inst_pc, inst_is_compressed
    );

    modport slave (
        input  fetch_valid, fetch_data, fetch_pc, flush, flush_pc, inst_ready,
        output fetch_ready, inst_valid, inst_data, inst_pc, inst_is_compressed
    );
endinterface

// File: rtl/inst_aligner.sv
// Splits word-aligned 32-bit fetch words into a stream of 16/32-bit instructions,
// stitching instructions that straddle two fetch words via a held halfword.
module inst_aligner (
    input  logic           clk,
    input  logic           reset_n,
    inst_aligner_if.slave  bus
);

    logic        w_valid_r;
    logic [31:0] w_data_r;
    logic [31:0] w_pc_r;
    logic        w_off_r;
    logic        h_valid_r;
    logic [15:0] h_data_r;
    logic [31:0] h_pc_r;
    logic        skip_low_r;

    logic        inst_valid_s;
    logic [31:0] inst_data_s;
    logic [31:0] inst_pc_s;
    logic        adv_off_s;
    logic        clear_w_s;
    logic        move_h_s;
    logic        handshake_s;
    logic        w_drain_s;
    logic        fetch_ready_s;
    logic        accept_s;

    // Output selection from registered H/W state, plus the state-update intents.
    always_comb begin
        inst_valid_s = 1'b0;
        inst_data_s  = 32'h0000_0000;
        inst_pc_s    = 32'h0000_0000;
        adv_off_s    = 1'b0;
        clear_w_s    = 1'b0;
        move_h_s     = 1'b0;
        if (h_valid_r) begin
            if (w_valid_r) begin
                inst_valid_s = 1'b1;
                inst_data_s  = {w_data_r[15:0], h_data_r};
                inst_pc_s    = h_pc_r;
                adv_off_s    = 1'b1;
            end else begin
                inst_valid_s = 1'b0;
            end
        end else if (w_valid_r) begin
            if (!w_off_r) begin
                inst_valid_s = 1'b1;
                inst_pc_s    = w_pc_r;
                if (w_data_r[1:0] != 2'b11) begin
                    inst_data_s = {16'h0000, w_data_r[15:0]};
                    adv_off_s   = 1'b1;
                end else begin
                    inst_data_s = w_data_r;
                    clear_w_s   = 1'b1;
                end
            end else begin
                if (w_data_r[17:16] != 2'b11) begin
                    inst_valid_s = 1'b1;
                    inst_data_s  = {16'h0000, w_data_r[31:16]};
                    inst_pc_s    = w_pc_r + 32'd2;
                    clear_w_s    = 1'b1;
                end else begin
                    // Upper half starts a 32-bit instruction: park it in H (one bubble).
                    move_h_s = 1'b1;
                end
            end
        end else begin
            inst_valid_s = 1'b0;
        end
    end

    assign handshake_s   = inst_valid_s & bus.inst_ready & ~bus.flush;
    assign w_drain_s     = (handshake_s & clear_w_s) | move_h_s;
    assign fetch_ready_s = ~bus.flush & (~w_valid_r | w_drain_s);
    assign accept_s      = bus.fetch_valid & fetch_ready_s;

    assign bus.fetch_ready        = fetch_ready_s;
    assign bus.inst_valid         = inst_valid_s;
    assign bus.inst_data          = inst_data_s;
    assign bus.inst_pc            = inst_pc_s;
    assign bus.inst_is_compressed = inst_valid_s & (inst_data_s[1:0] != 2'b11);

    // Word/halfword buffer and redirect-offset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_valid_r  <= 1'b0;
            w_data_r   <= 32'h0000_0000;
            w_pc_r     <= 32'h0000_0000;
            w_off_r    <= 1'b0;
            h_valid_r  <= 1'b0;
            h_data_r   <= 16'h0000;
            h_pc_r     <= 32'h0000_0000;
            skip_low_r <= 1'b0;
        end else if (bus.flush) begin
            w_valid_r  <= 1'b0;
            h_valid_r  <= 1'b0;
            skip_low_r <= bus.flush_pc[1];
        end else begin
            if (handshake_s && adv_off_s) begin
                w_off_r <= 1'b1;
            end
            if (handshake_s && clear_w_s) begin
                w_valid_r <= 1'b0;
            end
            if (handshake_s && h_valid_r) begin
                h_valid_r <= 1'b0;
            end
            if (move_h_s) begin
                h_valid_r <= 1'b1;
                h_data_r  <= w_data_r[31:16];
                h_pc_r    <= w_pc_r + 32'd2;
                w_valid_r <= 1'b0;
            end
            // A new word may land in the same cycle W drains.
            if (accept_s) begin
                w_valid_r  <= 1'b1;
                w_data_r   <= bus.fetch_data;
                w_pc_r     <= {bus.fetch_pc[31:2], 2'b00};
                w_off_r    <= skip_low_r;
                skip_low_r <= 1'b0;
            end
        end
    end

endmodule
